// File: rtl/mc_control_unit_v2.sv
// Multicycle RV32I control unit with variable-latency memory handshake,
// optional multiply/divide handshake, illegal-opcode trap, halt state and
// cycle / retired-instruction counters. Datapath controls are decoded
// combinationally from the current state so they follow reset at once.
module mc_control_unit_v2 #(
    parameter logic MEM_WAIT_EN = 1'b1,
    parameter logic MDU_EN      = 1'b1,
    parameter logic TRAP_EN     = 1'b1,
    parameter int   CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           instruction_opcode,
    input  logic                 funct7_0,
    input  logic                 mem_ready,
    input  logic                 mdu_done,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 pc_source,
    output logic                 reg_write,
    output logic                 memory_read,
    output logic                 memory_write,
    output logic                 pc_write_cond,
    output logic                 lorD,
    output logic                 memory_to_reg,
    output logic                 is_immediate,
    output logic [1:0]           aluop,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 mdu_start,
    output logic                 trap,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_MDU_WAIT = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_TRAP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_WIDTH-1:0]   cycle_count_r;
    logic [CNT_WIDTH-1:0]   instret_count_r;
    logic                   mem_ok_s;
    logic                   fetch_done_s;
    logic                   mdu_sel_s;
    logic                   retire_s;

    // With the wait handshake disabled every memory access completes at once.
    assign mem_ok_s     = MEM_WAIT_EN ? mem_ready : 1'b1;
    // No IR/PC update may leak out while the core is held in reset.
    assign fetch_done_s = rst_n & mem_ok_s;
    assign mdu_sel_s    = MDU_EN & funct7_0 & (instruction_opcode == OP_R);

    // An instruction retires on the edge that returns from a completing state.
    assign retire_s = (state_r == S_MEMWB) ||
                      ((state_r == S_MEMWRITE) && mem_ok_s) ||
                      (state_r == S_ALUWB) ||
                      (state_r == S_BRANCH);

    assign cycle_count   = cycle_count_r;
    assign instret_count = instret_count_r;

    // Next-state selection; unknown encodings recover to FETCH.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ok_s) state_nxt_s = S_DECODE;
                else          state_nxt_s = S_FETCH;
            end
            S_DECODE: begin
                case (instruction_opcode)
                    OP_LW, OP_SW:                      state_nxt_s = S_MEMADR;
                    OP_R, OP_I, OP_AUIPC, OP_LUI:      state_nxt_s = S_EXECUTE;
                    OP_BR:                             state_nxt_s = S_BRANCH;
                    OP_JAL:                            state_nxt_s = S_JAL;
                    OP_JALR:                           state_nxt_s = S_JALR;
                    OP_SYS:                            state_nxt_s = S_HALT;
                    default: begin
                        if (TRAP_EN) state_nxt_s = S_TRAP;
                        else         state_nxt_s = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                if (instruction_opcode == OP_LW) state_nxt_s = S_MEMREAD;
                else                             state_nxt_s = S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ok_s) state_nxt_s = S_MEMWB;
                else          state_nxt_s = S_MEMREAD;
            end
            S_MEMWB:    state_nxt_s = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ok_s) state_nxt_s = S_FETCH;
                else          state_nxt_s = S_MEMWRITE;
            end
            S_EXECUTE: begin
                if (mdu_sel_s) state_nxt_s = S_MDU_WAIT;
                else           state_nxt_s = S_ALUWB;
            end
            S_MDU_WAIT: begin
                if (mdu_done) state_nxt_s = S_ALUWB;
                else          state_nxt_s = S_MDU_WAIT;
            end
            S_ALUWB:  state_nxt_s = S_FETCH;
            S_BRANCH: state_nxt_s = S_FETCH;
            S_JAL:    state_nxt_s = S_ALUWB;
            S_JALR:   state_nxt_s = S_ALUWB;
            S_TRAP:   state_nxt_s = S_HALT;
            S_HALT:   state_nxt_s = S_HALT;
            default:  state_nxt_s = S_FETCH;
        endcase
    end

    // State register; reset discards any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_FETCH;
        else        state_r <= state_nxt_s;
    end

    // Performance counters: cycles stop in HALT, instret counts completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_r   <= {CNT_WIDTH{1'b0}};
            instret_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (state_r != S_HALT) cycle_count_r <= cycle_count_r + CNT_ONE;
            else                   cycle_count_r <= cycle_count_r;
            if (retire_s) instret_count_r <= instret_count_r + CNT_ONE;
            else          instret_count_r <= instret_count_r;
        end
    end

    // Datapath control decode; everything defaults low in every state.
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        pc_source     = 1'b0;
        reg_write     = 1'b0;
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        pc_write_cond = 1'b0;
        lorD          = 1'b0;
        memory_to_reg = 1'b0;
        is_immediate  = 1'b0;
        aluop         = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        mdu_start     = 1'b0;
        trap          = 1'b0;
        halted        = 1'b0;
        case (state_r)
            S_FETCH: begin
                memory_read = 1'b1;
                alu_src_b   = 2'b01;
                ir_write    = fetch_done_s;
                pc_write    = fetch_done_s;
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                memory_read = 1'b1;
                lorD        = 1'b1;
            end
            S_MEMWB: begin
                reg_write     = 1'b1;
                memory_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                memory_write = 1'b1;
                lorD         = 1'b1;
            end
            S_EXECUTE: begin
                case (instruction_opcode)
                    OP_R: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b00;
                        aluop     = 2'b10;
                        mdu_start = mdu_sel_s;
                    end
                    OP_I: begin
                        alu_src_a    = 2'b01;
                        alu_src_b    = 2'b10;
                        aluop        = 2'b10;
                        is_immediate = 1'b1;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b10;
                    end
                    OP_LUI: begin
                        alu_src_a = 2'b11;
                        alu_src_b = 2'b10;
                    end
                    default: begin
                        alu_src_a = 2'b00;
                    end
                endcase
            end
            S_MDU_WAIT: begin
                aluop     = 2'b11;
                alu_src_a = 2'b01;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b00;
                aluop         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            S_JAL, S_JALR: begin
                pc_write     = 1'b1;
                pc_source    = 1'b1;
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                is_immediate = (state_r == S_JALR);
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule
